// File: rtl/rvtu_tag_ctrl.sv
// Tag-array controller for a 128-set cache: fill writes, lookups with hit/victim report, dirty-on-store update.
// Define RVTU_TAG_INIT_EN to zero the whole array with a hardware sweep after reset.
module rvtu_tag_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic        fill_valid,
    output logic        fill_ready,
    input  logic [6:0]  fill_index,
    input  logic [19:0] fill_tag,
    input  logic        fill_dirty,
    output logic        resp_valid,
    output logic        resp_hit,
    output logic        resp_victim_valid,
    output logic        resp_victim_dirty,
    output logic [19:0] resp_victim_tag,
    output logic [6:0]  tag_addr,
    output logic [21:0] tag_wdata,
    output logic        tag_wen,
    input  logic [21:0] tag_rdata,
    output logic        init_done
);

    typedef enum logic [1:0] {INIT, IDLE, LOOKUP, UPDATE} state_t;

`ifdef RVTU_TAG_INIT_EN
    localparam state_t ResetState = INIT;
`else
    localparam state_t ResetState = IDLE;
`endif

    state_t      state_q;
    logic [6:0]  initCnt_q;
    logic [6:0]  savedIndex_q;
    logic [19:0] savedTag_q;
    logic        savedWrite_q;
    logic        respValid_q;
    logic        respHit_q;
    logic        victimValid_q;
    logic        victimDirty_q;
    logic [19:0] victimTag_q;
    logic        initDone_q;

    logic lookupHit;
    logic unusedOffsetBits;

    assign unusedOffsetBits = ^req_addr[4:0];
    assign lookupHit = tag_rdata[21] && (tag_rdata[19:0] == savedTag_q);

    assign resp_valid        = respValid_q;
    assign resp_hit          = respHit_q;
    assign resp_victim_valid = victimValid_q;
    assign resp_victim_dirty = victimDirty_q;
    assign resp_victim_tag   = victimTag_q;
    assign init_done         = initDone_q;

    // Array port and handshakes are combinational so a fill lands in its own handshake cycle.
    always_comb begin
        req_ready  = 1'b0;
        fill_ready = 1'b0;
        tag_wen    = 1'b0;
        tag_addr   = 7'd0;
        tag_wdata  = 22'd0;
        if (!rst) begin
            case (state_q)
                INIT: begin
                    tag_wen  = 1'b1;
                    tag_addr = initCnt_q;
                end
                IDLE: begin
                    fill_ready = 1'b1;
                    req_ready  = ~fill_valid;
                    if (fill_valid) begin
                        tag_wen   = 1'b1;
                        tag_addr  = fill_index;
                        tag_wdata = {1'b1, fill_dirty, fill_tag};
                    end else begin
                        tag_addr = req_addr[11:5];
                    end
                end
                UPDATE: begin
                    tag_wen   = 1'b1;
                    tag_addr  = savedIndex_q;
                    tag_wdata = {2'b11, savedTag_q};
                end
                default: tag_addr = savedIndex_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ResetState;
            initCnt_q     <= 7'd0;
            savedIndex_q  <= 7'd0;
            savedTag_q    <= 20'd0;
            savedWrite_q  <= 1'b0;
            respValid_q   <= 1'b0;
            respHit_q     <= 1'b0;
            victimValid_q <= 1'b0;
            victimDirty_q <= 1'b0;
            victimTag_q   <= 20'd0;
            initDone_q    <= 1'b0;
        end else begin
            respValid_q <= 1'b0;
            case (state_q)
                INIT: begin
                    initCnt_q <= initCnt_q + 7'd1;
                    if (initCnt_q == 7'd127) begin
                        state_q    <= IDLE;
                        initDone_q <= 1'b1;
                    end
                end
                IDLE: begin
                    initDone_q <= 1'b1;
                    if (req_valid && !fill_valid) begin
                        savedIndex_q <= req_addr[11:5];
                        savedTag_q   <= req_addr[31:12];
                        savedWrite_q <= req_write;
                        state_q      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    respValid_q   <= 1'b1;
                    respHit_q     <= lookupHit;
                    victimValid_q <= tag_rdata[21];
                    victimDirty_q <= tag_rdata[20];
                    victimTag_q   <= tag_rdata[19:0];
                    // Only a store hitting a clean line needs the dirty bit written back.
                    if (lookupHit && savedWrite_q && !tag_rdata[20]) begin
                        state_q <= UPDATE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvtu_tag_ctrl.sv
// Directed bench for rvtu_tag_ctrl with a behavioural 128x22 tag array (1-cycle read latency).
module tb_rvtu_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic        fill_valid;
    logic        fill_ready;
    logic [6:0]  fill_index;
    logic [19:0] fill_tag;
    logic        fill_dirty;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_victim_valid;
    logic        resp_victim_dirty;
    logic [19:0] resp_victim_tag;
    logic [6:0]  tag_addr;
    logic [21:0] tag_wdata;
    logic        tag_wen;
    logic [21:0] tag_rdata;
    logic        init_done;

    logic [21:0] tagMem [128];
    int          wrCount = 0;
    int          checkCount = 0;
    int          failCount = 0;

    rvtu_tag_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_write         (req_write),
        .fill_valid        (fill_valid),
        .fill_ready        (fill_ready),
        .fill_index        (fill_index),
        .fill_tag          (fill_tag),
        .fill_dirty        (fill_dirty),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_victim_valid (resp_victim_valid),
        .resp_victim_dirty (resp_victim_dirty),
        .resp_victim_tag   (resp_victim_tag),
        .tag_addr          (tag_addr),
        .tag_wdata         (tag_wdata),
        .tag_wen           (tag_wen),
        .tag_rdata         (tag_rdata),
        .init_done         (init_done)
    );

    always #5 clk = ~clk;

    // Array model: synchronous write, registered read returning the pre-write contents.
    always @(posedge clk) begin
        if (tag_wen) begin
            tagMem[tag_addr] <= tag_wdata;
            wrCount          <= wrCount + 1;
        end
        tag_rdata <= tagMem[tag_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [6:0] fi, input logic [19:0] ft, input logic fd,
                                 input logic rv, input logic [31:0] ra, input logic rw);
        fill_valid = fv;
        fill_index = fi;
        fill_tag   = ft;
        fill_dirty = fd;
        req_valid  = rv;
        req_addr   = ra;
        req_write  = rw;
    endtask

    // Drive a new vector just after the falling edge, then settle before sampling.
    task automatic step(input logic fv, input logic [6:0] fi, input logic [19:0] ft, input logic fd,
                        input logic rv, input logic [31:0] ra, input logic rw);
        @(negedge clk);
        applyStimulus(fv, fi, ft, fd, rv, ra, rw);
        #1;
    endtask

    task automatic idleStep();
        step(1'b0, 7'd0, 20'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        int wrSnap;
        logic sawResp;
        logic reachedIdle;
        for (int i = 0; i < 128; i++) tagMem[i] = 22'h155555;
`ifndef RVTU_TAG_INIT_EN
        for (int i = 0; i < 128; i++) tagMem[i] = 22'd0;
`endif
        rst = 1'b1;
        applyStimulus(1'b0, 7'd0, 20'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        idleStep();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_fill_ready", 32'(fill_ready), 32'd0);
        checkOutput("rst_tag_wen", 32'(tag_wen), 32'd0);
        checkOutput("rst_init_done", 32'(init_done), 32'd0);
        checkOutput("rst_resp", 32'({resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty, resp_victim_tag}), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef RVTU_TAG_INIT_EN
        for (int i = 0; i < 128; i++) begin
            checkOutput("sweep_write", {9'd0, tag_wen, tag_addr, tag_wdata[14:0]} | 32'(tag_wdata[21:15] << 23),
                        {9'd0, 1'b1, 7'(i), 15'd0});
            if (i != 127) idleStep();
        end
`endif
        idleStep();
        checkOutput("init_done", 32'(init_done), 32'd1);
        checkOutput("ready_after_init", 32'(req_ready), 32'd1);
        checkOutput("array_zeroed", 32'(tagMem[5] | tagMem[9] | tagMem[127]), 32'd0);

        step(1'b1, 7'd5, 20'hABCDE, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("fill_ready", 32'(fill_ready), 32'd1);
        checkOutput("fill_write", {tag_wen, 2'b00, tag_addr, tag_wdata}, {1'b1, 2'b00, 7'd5, 22'h2ABCDE});

        step(1'b0, 7'd0, 20'd0, 1'b0, 1'b1, 32'hABCDE0A0, 1'b0);
        wrSnap = wrCount;
        checkOutput("rd_accept", {30'd0, req_ready, tag_wen}, 32'b10);
        checkOutput("rd_index", 32'(tag_addr), 32'd5);
        idleStep();
        checkOutput("rd_n1_no_resp", {30'd0, resp_valid, req_ready}, 32'b00);
        idleStep();
        checkOutput("rd_resp", {resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty, 8'd0, resp_victim_tag},
                    {4'b1110, 8'd0, 20'hABCDE});
        checkOutput("rd_n2_ready", {30'd0, req_ready, tag_wen}, 32'b10);
        idleStep();
        checkOutput("rd_pulse_end", 32'(resp_valid), 32'd0);
        checkOutput("rd_no_update", 32'(wrCount), 32'(wrSnap));

        step(1'b0, 7'd0, 20'd0, 1'b0, 1'b1, 32'hABCDE0A0, 1'b1);
        checkOutput("wr_accept", 32'(req_ready), 32'd1);
        idleStep();
        idleStep();
        checkOutput("wr_resp", {28'd0, resp_valid, resp_hit, resp_victim_dirty, 1'b0}, 32'b1100);
        checkOutput("wr_update", {tag_wen, 2'b00, tag_addr, tag_wdata}, {1'b1, 2'b00, 7'd5, 22'h3ABCDE});
        checkOutput("wr_update_ready", {30'd0, req_ready, fill_ready}, 32'b00);
        idleStep();
        checkOutput("wr_after_update", {30'd0, req_ready, tag_wen}, 32'b10);

        step(1'b0, 7'd0, 20'd0, 1'b0, 1'b1, 32'hABCDE0A0, 1'b1);
        wrSnap = wrCount;
        idleStep();
        idleStep();
        checkOutput("wr2_resp", {28'd0, resp_valid, resp_hit, resp_victim_dirty, tag_wen}, 32'b1110);
        idleStep();
        checkOutput("wr2_no_write", 32'(wrCount), 32'(wrSnap));

        step(1'b0, 7'd0, 20'd0, 1'b0, 1'b1, 32'h123450A0, 1'b0);
        wrSnap = wrCount;
        idleStep();
        idleStep();
        checkOutput("miss_resp", {resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty, 8'd0, resp_victim_tag},
                    {4'b1011, 8'd0, 20'hABCDE});
        idleStep();
        checkOutput("miss_no_write", 32'(wrCount), 32'(wrSnap));

        step(1'b1, 7'd9, 20'h11111, 1'b1, 1'b1, 32'h11111120, 1'b0);
        checkOutput("both_req_ready", 32'(req_ready), 32'd0);
        checkOutput("both_fill_write", {tag_wen, 2'b00, tag_addr, tag_wdata}, {1'b1, 2'b00, 7'd9, 22'h311111});
        step(1'b0, 7'd0, 20'd0, 1'b0, 1'b1, 32'h11111120, 1'b0);
        checkOutput("both_accept", {30'd0, req_ready, tag_wen}, 32'b10);
        idleStep();
        idleStep();
        checkOutput("both_resp", {28'd0, resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty}, 32'b1111);

        idleStep();
        step(1'b0, 7'd0, 20'd0, 1'b0, 1'b1, 32'hABCDE0A0, 1'b1);
        checkOutput("abort_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 7'd0, 20'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("abort_in_reset", {29'd0, resp_valid, tag_wen, req_ready}, 32'b000);
        idleStep();
        checkOutput("abort_no_pulse", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef RVTU_TAG_INIT_EN
        checkOutput("abort_sweep_restart", {24'd0, tag_wen, tag_addr}, {24'd0, 1'b1, 7'd0});
`endif
        sawResp = resp_valid;
        reachedIdle = 1'b0;
        for (int c = 0; c < 200 && !reachedIdle; c++) begin
            idleStep();
            sawResp = sawResp | resp_valid;
            reachedIdle = init_done & req_ready;
        end
        checkOutput("abort_recovered", 32'(reachedIdle), 32'd1);
        checkOutput("abort_no_resp", 32'(sawResp), 32'd0);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
